// File: rtl/ram_arb_pkg.sv
// Shared types and the round-robin grant function for the ram_arb block.
package ram_arb_pkg;

  localparam int REQS_MAX   = 8;
  localparam int ADDR_W_DEF = 13;

  typedef logic [REQS_MAX-1:0]   req_vec_t;
  typedef logic [ADDR_W_DEF-1:0] addr_slice_t;

  // One-hot grant to the first request at or after ptr, wrapping modulo n.
  function automatic req_vec_t rr_next(input logic [2:0] ptr, input req_vec_t req,
                                       input int unsigned n);
    req_vec_t    gnt;
    int unsigned s;
    logic [2:0]  idx;
    logic        found;
    gnt   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < REQS_MAX; k++) begin
      s = {29'd0, ptr} + k;
      if (s >= n) s = s - n;
      idx = s[2:0];
      if (k < n && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/ram_arb_rr_arb.sv
// rr_arb: round-robin arbiter, combinational one-hot grant, pointer advances past each winner.
// Grant is forced to zero while reset is low; requesters hold their request until granted.
module rr_arb
  import ram_arb_pkg::*;
#(
  parameter int REQS = 4
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [REQS-1:0] i_req,
  output logic [REQS-1:0] o_gnt
);

  localparam int REQ_W = $clog2(REQS);

  logic [REQ_W-1:0] r_ptr;
  logic [REQ_W-1:0] w_idx;
  logic [REQ_W-1:0] w_ptr_nxt;
  req_vec_t         w_gnt_ext;

  always_comb begin
    w_gnt_ext = rr_next(3'(r_ptr), REQS_MAX'(i_req), REQS);
  end

  // Encoding over the full vector; bits at or above REQS are always zero.
  always_comb begin
    w_idx = '0;
    for (int i = 0; i < REQS_MAX; i++) begin
      if (w_gnt_ext[i]) w_idx = REQ_W'(i);
    end
  end

  assign w_ptr_nxt = (w_idx == REQ_W'(REQS-1)) ? '0 : w_idx + REQ_W'(1);
  assign o_gnt     = i_rst_n ? w_gnt_ext[REQS-1:0] : '0;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_ptr <= '0;
    end else if (|o_gnt) begin
      r_ptr <= w_ptr_nxt;
    end
  end

endmodule

// File: rtl/ram_arb.sv
// ram_arb: two independent round-robin ports onto one dual-port RAM; combinational acks, read data after RD_LAT.
// Requesters hold req until ack. Build option RAM_ARB_BYPASS_EN makes same-cycle write/read collisions write-first.
module ram_arb
  import ram_arb_pkg::*;
#(
  parameter int REQS   = 4,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 13,
  parameter int RD_LAT = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic [REQS-1:0]          wr_req_i,
  input  logic [REQS*ADDR_W-1:0]   wr_addr_i,
  input  logic [REQS*DATA_W-1:0]   wr_data_i,
  output logic [REQS-1:0]          wr_ack_o,
  input  logic [REQS-1:0]          rd_req_i,
  input  logic [REQS*ADDR_W-1:0]   rd_addr_i,
  output logic [REQS-1:0]          rd_ack_o,
  output logic [DATA_W-1:0]        rd_data_o,
  output logic [REQS-1:0]          rd_vld_o,
  output logic [ADDR_W-1:0]        ram_wr_addr_o,
  output logic                     ram_wr_en_o,
  output logic [DATA_W-1:0]        ram_wr_data_o,
  output logic [ADDR_W-1:0]        ram_rd_addr_o,
  input  logic [DATA_W-1:0]        ram_rd_data_i
);

  logic [ADDR_W-1:0] w_wr_addr;
  logic [DATA_W-1:0] w_wr_data;
  logic [ADDR_W-1:0] w_rd_addr;
  logic              w_rd_any;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [REQS-1:0]   r_vld_pipe [RD_LAT];

  rr_arb #(.REQS(REQS)) u_wr_arb (
    .i_clk   (clk_i),
    .i_rst_n (rst_n_i),
    .i_req   (wr_req_i),
    .o_gnt   (wr_ack_o)
  );

  rr_arb #(.REQS(REQS)) u_rd_arb (
    .i_clk   (clk_i),
    .i_rst_n (rst_n_i),
    .i_req   (rd_req_i),
    .o_gnt   (rd_ack_o)
  );

  // Grants are one-hot, so an AND-OR mux selects the winner's slice (zero when idle).
  always_comb begin
    w_wr_addr = '0;
    w_wr_data = '0;
    w_rd_addr = '0;
    for (int n = 0; n < REQS; n++) begin
      if (wr_ack_o[n]) begin
        w_wr_addr = w_wr_addr | wr_addr_i[n*ADDR_W +: ADDR_W];
        w_wr_data = w_wr_data | wr_data_i[n*DATA_W +: DATA_W];
      end
      if (rd_ack_o[n]) begin
        w_rd_addr = w_rd_addr | rd_addr_i[n*ADDR_W +: ADDR_W];
      end
    end
  end

  assign w_rd_any      = |rd_ack_o;
  assign ram_wr_en_o   = |wr_ack_o;
  assign ram_wr_addr_o = w_wr_addr;
  assign ram_wr_data_o = w_wr_data;
  assign ram_rd_addr_o = w_rd_any ? w_rd_addr : r_rd_addr;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_rd_addr <= '0;
    end else if (w_rd_any) begin
      r_rd_addr <= w_rd_addr;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < RD_LAT; i++) r_vld_pipe[i] <= '0;
    end else begin
      r_vld_pipe[0] <= rd_ack_o;
      for (int i = 1; i < RD_LAT; i++) r_vld_pipe[i] <= r_vld_pipe[i-1];
    end
  end

  assign rd_vld_o = r_vld_pipe[RD_LAT-1];

`ifdef RAM_ARB_BYPASS_EN
  logic              w_byp_hit;
  logic              r_byp_pipe [RD_LAT];
  logic [DATA_W-1:0] r_byp_data [RD_LAT];

  assign w_byp_hit = w_rd_any && ram_wr_en_o && (w_rd_addr == w_wr_addr);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < RD_LAT; i++) begin
        r_byp_pipe[i] <= 1'b0;
        r_byp_data[i] <= '0;
      end
    end else begin
      r_byp_pipe[0] <= w_byp_hit;
      r_byp_data[0] <= w_wr_data;
      for (int i = 1; i < RD_LAT; i++) begin
        r_byp_pipe[i] <= r_byp_pipe[i-1];
        r_byp_data[i] <= r_byp_data[i-1];
      end
    end
  end

  assign rd_data_o = r_byp_pipe[RD_LAT-1] ? r_byp_data[RD_LAT-1] : ram_rd_data_i;
`else
  assign rd_data_o = ram_rd_data_i;
`endif

endmodule

// File: tb/tb_ram_arb.sv
// Bench for ram_arb: behavioural RAM (read-before-write, 2-cycle read) plus a transaction-level reference model.
module tb_ram_arb;

  localparam int REQS   = 4;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 13;
  localparam int RD_LAT = 2;

  typedef struct {
    int               due;
    int               req;
    logic [DATA_W-1:0] d;
  } rd_ent_t;

  logic                   clk;
  logic                   rst_n;
  logic [REQS-1:0]        wr_req, rd_req;
  logic [REQS*ADDR_W-1:0] wr_addr, rd_addr;
  logic [REQS*DATA_W-1:0] wr_data;
  logic [REQS-1:0]        wr_ack_o, rd_ack_o, rd_vld_o;
  logic [DATA_W-1:0]      rd_data_o, ram_wr_data_o, ram_rd_data;
  logic [ADDR_W-1:0]      ram_wr_addr_o, ram_rd_addr_o;
  logic                   ram_wr_en_o;

  ram_arb #(.REQS(REQS), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .wr_req_i      (wr_req),
    .wr_addr_i     (wr_addr),
    .wr_data_i     (wr_data),
    .wr_ack_o      (wr_ack_o),
    .rd_req_i      (rd_req),
    .rd_addr_i     (rd_addr),
    .rd_ack_o      (rd_ack_o),
    .rd_data_o     (rd_data_o),
    .rd_vld_o      (rd_vld_o),
    .ram_wr_addr_o (ram_wr_addr_o),
    .ram_wr_en_o   (ram_wr_en_o),
    .ram_wr_data_o (ram_wr_data_o),
    .ram_rd_addr_o (ram_rd_addr_o),
    .ram_rd_data_i (ram_rd_data)
  );

  // Block RAM stand-in: registered address plus registered output.
  logic [DATA_W-1:0] ram_mem [2**ADDR_W];
  logic [DATA_W-1:0] ram_q1, ram_q2;
  always @(posedge clk) begin
    ram_q1 <= ram_mem[ram_rd_addr_o];
    ram_q2 <= ram_q1;
    if (ram_wr_en_o) ram_mem[ram_wr_addr_o] <= ram_wr_data_o;
  end
  assign ram_rd_data = ram_q2;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  // Reference model state
  int                m_wptr = 0, m_rptr = 0, m_cyc = 0;
  logic [ADDR_W-1:0] m_last_rd = '0;
  logic [DATA_W-1:0] ref_mem [2**ADDR_W];
  rd_ent_t           m_q[$];

  logic [REQS-1:0]   e_wr_ack, e_rd_ack, e_vld;
  logic [ADDR_W-1:0] e_wr_addr, e_rd_addr;
  logic [DATA_W-1:0] e_wr_data, e_data;
  int                e_wg, e_rg;

  task automatic model_eval();
    int wi, ri;
    e_wr_ack = '0; e_rd_ack = '0; e_wg = -1; e_rg = -1;
    if (rst_n) begin
      for (int k = 0; k < REQS; k++) begin
        wi = (m_wptr + k) % REQS;
        ri = (m_rptr + k) % REQS;
        if (e_wg < 0 && wr_req[wi]) e_wg = wi;
        if (e_rg < 0 && rd_req[ri]) e_rg = ri;
      end
    end
    e_wr_addr = '0; e_wr_data = '0; e_rd_addr = m_last_rd;
    if (e_wg >= 0) begin
      e_wr_ack[e_wg] = 1'b1;
      e_wr_addr = wr_addr[e_wg*ADDR_W +: ADDR_W];
      e_wr_data = wr_data[e_wg*DATA_W +: DATA_W];
    end
    if (e_rg >= 0) begin
      e_rd_ack[e_rg] = 1'b1;
      e_rd_addr = rd_addr[e_rg*ADDR_W +: ADDR_W];
    end
    e_vld = '0; e_data = '0;
    if (m_q.size() > 0 && m_q[0].due == m_cyc) begin
      e_vld[m_q[0].req] = 1'b1;
      e_data = m_q[0].d;
    end
  endtask

  task automatic model_commit();
    rd_ent_t t;
    if (!rst_n) begin
      m_q.delete();
      m_wptr = 0; m_rptr = 0; m_last_rd = '0;
    end else begin
      if (m_q.size() > 0 && m_q[0].due == m_cyc) void'(m_q.pop_front());
      if (e_rg >= 0) begin
        t.due = m_cyc + RD_LAT;
        t.req = e_rg;
        t.d   = ref_mem[e_rd_addr];
`ifdef RAM_ARB_BYPASS_EN
        if (e_wg >= 0 && e_wr_addr == e_rd_addr) t.d = e_wr_data;
`endif
        m_q.push_back(t);
        m_last_rd = e_rd_addr;
        m_rptr = (e_rg + 1) % REQS;
      end
      if (e_wg >= 0) begin
        ref_mem[e_wr_addr] = e_wr_data;
        m_wptr = (e_wg + 1) % REQS;
      end
    end
    m_cyc++;
  endtask

  task automatic adv();
    model_commit();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_wr(input int n, input int a, input logic [DATA_W-1:0] d);
    wr_req[n] = 1'b1;
    wr_addr[n*ADDR_W +: ADDR_W] = ADDR_W'(a);
    wr_data[n*DATA_W +: DATA_W] = d;
  endtask

  task automatic set_rd(input int n, input int a);
    rd_req[n] = 1'b1;
    rd_addr[n*ADDR_W +: ADDR_W] = ADDR_W'(a);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      wr_req = REQS'($urandom); rd_req = REQS'($urandom);
      #1; model_eval();
      total++;
      if ({wr_ack_o, rd_ack_o, ram_wr_en_o} !== '0) begin
        bad++; $display("FAIL reset_acks got wr=%b rd=%b en=%b want all 0", wr_ack_o, rd_ack_o, ram_wr_en_o);
      end
      total++;
      if (rd_vld_o !== '0) begin
        bad++; $display("FAIL reset_vld got %b want 0", rd_vld_o);
      end
      adv();
    end
    rst_n = 1'b1; wr_req = '0; rd_req = '0;
    for (int c = 0; c < 3; c++) begin
      #1; model_eval();
      total++;
      if ({wr_ack_o, rd_ack_o, ram_wr_en_o, rd_vld_o} !== '0) begin
        bad++; $display("FAIL idle got wr=%b rd=%b en=%b vld=%b want all 0", wr_ack_o, rd_ack_o, ram_wr_en_o, rd_vld_o);
      end
      adv();
    end
    for (int a = 0; a < 16; a++) begin
      set_wr(a % REQS, a, 16'hA000 + 16'(a));
      #1; model_eval();
      total++;
      if ({wr_ack_o, ram_wr_en_o, ram_wr_addr_o, ram_wr_data_o} !== {e_wr_ack, 1'b1, e_wr_addr, e_wr_data}) begin
        bad++; $display("FAIL preload_wr got ack=%b en=%b a=%h d=%h want ack=%b a=%h d=%h", wr_ack_o, ram_wr_en_o, ram_wr_addr_o, ram_wr_data_o, e_wr_ack, e_wr_addr, e_wr_data);
      end
      adv();
      wr_req = '0;
    end
  endtask

  task automatic test_write_read();
    set_wr(2, 5, 16'h1234);
    #1; model_eval();
    total++;
    if (wr_ack_o !== 4'b0100 || ram_wr_addr_o !== 13'd5 || ram_wr_data_o !== 16'h1234) begin
      bad++; $display("FAIL wr_grant got ack=%b a=%h d=%h want 0100 5 1234", wr_ack_o, ram_wr_addr_o, ram_wr_data_o);
    end
    adv(); wr_req = '0;
    set_rd(0, 5);
    #1; model_eval();
    total++;
    if (rd_ack_o !== 4'b0001 || ram_rd_addr_o !== 13'd5) begin
      bad++; $display("FAIL rd_grant got ack=%b a=%h want 0001 5", rd_ack_o, ram_rd_addr_o);
    end
    adv(); rd_req = '0;
    for (int j = 0; j < 3; j++) begin
      #1; model_eval();
      total++;
      if (rd_vld_o !== ((j == 1) ? 4'b0001 : 4'b0000) || (j == 1 && rd_data_o !== 16'h1234)) begin
        bad++; $display("FAIL wr_rd_return j=%0d got vld=%b d=%h want vld=%b d=1234", j, rd_vld_o, rd_data_o, (j == 1) ? 4'b0001 : 4'b0000);
      end
      adv();
    end
  endtask

  task automatic test_rotation();
    logic [REQS-1:0] x;
    rst_n = 1'b0;
    #1; model_eval(); adv();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      for (int n = 0; n < REQS; n++) set_rd(n, n);
      #1; model_eval();
      x = REQS'(1) << (i % REQS);
      total++;
      if (rd_ack_o !== x || rd_ack_o !== e_rd_ack) begin
        bad++; $display("FAIL rotate i=%0d got %b want %b", i, rd_ack_o, x);
      end
      total++;
      if (rd_vld_o !== e_vld || (|e_vld && rd_data_o !== e_data)) begin
        bad++; $display("FAIL rotate_ret i=%0d got vld=%b d=%h want vld=%b d=%h", i, rd_vld_o, rd_data_o, e_vld, e_data);
      end
      adv();
    end
    rd_req = '0;
    for (int j = 0; j < 3; j++) begin
      #1; model_eval();
      total++;
      if (rd_vld_o !== e_vld || (|e_vld && rd_data_o !== e_data)) begin
        bad++; $display("FAIL rotate_drain j=%0d got vld=%b d=%h want vld=%b d=%h", j, rd_vld_o, rd_data_o, e_vld, e_data);
      end
      adv();
    end
  endtask

  task automatic test_collision();
    logic [DATA_W-1:0] want;
`ifdef RAM_ARB_BYPASS_EN
    want = 16'hBEEF;
`else
    want = 16'h0001;
`endif
    set_wr(1, 7, 16'h0001);
    #1; model_eval(); adv(); wr_req = '0;
    set_wr(1, 7, 16'hBEEF); set_rd(3, 7);
    #1; model_eval();
    total++;
    if (wr_ack_o !== 4'b0010 || rd_ack_o !== 4'b1000) begin
      bad++; $display("FAIL collide_acks got wr=%b rd=%b want 0010 1000", wr_ack_o, rd_ack_o);
    end
    adv(); wr_req = '0; rd_req = '0;
    for (int j = 0; j < 3; j++) begin
      #1; model_eval();
      total++;
      if (rd_vld_o !== e_vld || (j == 1 && rd_data_o !== want)) begin
        bad++; $display("FAIL collide_ret j=%0d got vld=%b d=%h want vld=%b d=%h", j, rd_vld_o, rd_data_o, e_vld, want);
      end
      adv();
    end
  endtask

  task automatic test_reset_inflight();
    set_rd(1, 3);
    #1; model_eval(); adv(); rd_req = '0;
    rst_n = 1'b0;
    #1; model_eval();
    total++;
    if (rd_vld_o !== '0 || rd_ack_o !== '0) begin
      bad++; $display("FAIL inflight_rst got vld=%b ack=%b want 0", rd_vld_o, rd_ack_o);
    end
    adv(); rst_n = 1'b1;
    for (int j = 0; j < 3; j++) begin
      #1; model_eval();
      total++;
      if (rd_vld_o !== 4'b0000) begin
        bad++; $display("FAIL inflight_drop j=%0d got vld=%b want 0000", j, rd_vld_o);
      end
      adv();
    end
    for (int n = 0; n < REQS; n++) begin
      set_wr(n, 12 + n, 16'hC000 + 16'(n));
      set_rd(n, n);
    end
    #1; model_eval();
    total++;
    if (wr_ack_o !== 4'b0001 || rd_ack_o !== 4'b0001) begin
      bad++; $display("FAIL ptr_after_rst got wr=%b rd=%b want 0001 0001", wr_ack_o, rd_ack_o);
    end
    adv(); wr_req = '0; rd_req = '0;
  endtask

  task automatic test_same_req();
    set_wr(2, 9, 16'h5A5A); set_rd(2, 2);
    #1; model_eval();
    total++;
    if (wr_ack_o !== 4'b0100 || rd_ack_o !== 4'b0100 || ram_wr_en_o !== 1'b1) begin
      bad++; $display("FAIL same_req got wr=%b rd=%b en=%b want 0100 0100 1", wr_ack_o, rd_ack_o, ram_wr_en_o);
    end
    adv(); wr_req = '0; rd_req = '0;
    for (int j = 0; j < 3; j++) begin
      #1; model_eval();
      total++;
      if (rd_vld_o !== e_vld || (j == 1 && (rd_vld_o !== 4'b0100 || rd_data_o !== 16'hA002))) begin
        bad++; $display("FAIL same_req_ret j=%0d got vld=%b d=%h want vld=%b d=a002", j, rd_vld_o, rd_data_o, e_vld);
      end
      adv();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int n = 0; n < REQS; n++) begin
        if (!wr_req[n] && $urandom_range(0, 2) == 0) set_wr(n, int'($urandom_range(0, 15)), DATA_W'($urandom));
        if (!rd_req[n] && $urandom_range(0, 2) == 0) set_rd(n, int'($urandom_range(0, 15)));
      end
      #1; model_eval();
      total++;
      if ({wr_ack_o, rd_ack_o, ram_wr_en_o} !== {e_wr_ack, e_rd_ack, |e_wr_ack}) begin
        bad++; $display("FAIL rand_acks c=%0d got wr=%b rd=%b want wr=%b rd=%b", c, wr_ack_o, rd_ack_o, e_wr_ack, e_rd_ack);
      end
      total++;
      if ({ram_wr_addr_o, ram_wr_data_o, ram_rd_addr_o} !== {e_wr_addr, e_wr_data, e_rd_addr}) begin
        bad++; $display("FAIL rand_ram c=%0d got wa=%h wd=%h ra=%h want wa=%h wd=%h ra=%h", c, ram_wr_addr_o, ram_wr_data_o, ram_rd_addr_o, e_wr_addr, e_wr_data, e_rd_addr);
      end
      total++;
      if (rd_vld_o !== e_vld || (|e_vld && rd_data_o !== e_data)) begin
        bad++; $display("FAIL rand_ret c=%0d got vld=%b d=%h want vld=%b d=%h", c, rd_vld_o, rd_data_o, e_vld, e_data);
      end
      adv();
      wr_req = wr_req & ~e_wr_ack;
      rd_req = rd_req & ~e_rd_ack;
    end
  endtask

  initial begin
    rst_n = 1'b0; wr_req = '0; rd_req = '0;
    wr_addr = '0; rd_addr = '0; wr_data = '0;
    repeat (2) @(negedge clk);
    test_reset();
    test_write_read();
    test_rotation();
    test_collision();
    test_reset_inflight();
    test_same_req();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
